// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Central stall/flush controller for a classic 5-stage pipeline. It decides
//   every cycle what each pipeline register does (normal, flush, hold) and
//   whether the PC keeps its value. It covers memory freezes, taken branches,
//   jumps, multi-cycle multiply/divide occupancy and load-use hazards.
//
// Parameters:
//   REG_W    - register-specifier width
//   LOAD_LAT - load-use bubble cycles (1..7)
//   MD_LAT   - multiply/divide busy cycles (2..63)
//
// Ports:
//   clk                 in   rising-edge clock
//   reset               in   synchronous, active-high reset
//   mem_busy            in   data memory not ready; freeze the whole pipe
//   ex_mem_branch_taken in   branch resolved taken in MEM
//   id_ex_jump          in   J-type instruction in EX
//   id_ex_mem_read      in   load in EX
//   id_ex_rt            in   load destination register
//   if_id_rs, if_id_rt  in   source registers of the instruction in ID
//   md_start            in   multiply/divide entering execution in EX
//   if_id_op            out  IF/ID register control (00 normal, 01 flush, 10 hold)
//   id_ex_op            out  ID/EX register control
//   ex_mem_op           out  EX/MEM register control
//   pc_hold             out  1 = PC keeps its value
//   stall_cycles        out  (HAZARD_PERF_CNT_EN only) cycles stalled, excluding freezes
//   flush_events        out  (HAZARD_PERF_CNT_EN only) branch/jump flush cycles
//
// Configuration macro:
//   HAZARD_PERF_CNT_EN - adds the two 32-bit performance counters.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_busy,
  input  logic             ex_mem_branch_taken,
  input  logic             id_ex_jump,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             md_start,
  output logic [1:0]       if_id_op,
  output logic [1:0]       id_ex_op,
  output logic [1:0]       ex_mem_op,
  output logic             pc_hold
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
`endif
);

  localparam logic [1:0] OP_NORMAL = 2'b00;
  localparam logic [1:0] OP_FLUSH  = 2'b01;
  localparam logic [1:0] OP_HOLD   = 2'b10;

  // The first stall cycle is spent in IDLE, so LOAD_STALL only has to cover
  // the remaining LOAD_LAT-1 cycles, i.e. a counter start of LOAD_LAT-2.
  localparam logic [5:0] LOAD_INIT = (LOAD_LAT > 1) ? 6'(LOAD_LAT - 2) : 6'd0;
  localparam logic [5:0] MD_INIT   = 6'(MD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MD_BUSY    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       load_use;

  // Register 0 is hard-wired zero, so a load targeting it never creates a
  // real dependency.
  assign load_use = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  // Priority chain: reset, mem_busy, branch, then per-state handling where
  // jump beats load-use and load-use beats md_start.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    if_id_op  = OP_NORMAL;
    id_ex_op  = OP_NORMAL;
    ex_mem_op = OP_NORMAL;
    pc_hold   = 1'b0;

    if (reset) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end else if (mem_busy) begin
      if_id_op  = OP_HOLD;
      id_ex_op  = OP_HOLD;
      ex_mem_op = OP_HOLD;
      pc_hold   = 1'b1;
    end else if (ex_mem_branch_taken) begin
      // A taken branch squashes the younger instructions, including the one
      // stalled in a load bubble or a multiply/divide in progress.
      if_id_op = OP_FLUSH;
      id_ex_op = OP_FLUSH;
      state_d  = IDLE;
      cnt_d    = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (id_ex_jump) begin
            if_id_op = OP_FLUSH;
          end else if (load_use) begin
            if_id_op = OP_HOLD;
            id_ex_op = OP_FLUSH;
            pc_hold  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LOAD_INIT;
            end
          end else if (md_start) begin
            state_d = MD_BUSY;
            cnt_d   = MD_INIT;
          end
        end
        LOAD_STALL: begin
          if_id_op = OP_HOLD;
          id_ex_op = OP_FLUSH;
          pc_hold  = 1'b1;
          if (cnt_q == 6'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        MD_BUSY: begin
          // The multiply/divide stays in EX while bubbles drain into MEM.
          if_id_op  = OP_HOLD;
          id_ex_op  = OP_HOLD;
          ex_mem_op = OP_FLUSH;
          pc_hold   = 1'b1;
          if (cnt_q == 6'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_ff @(posedge clk) begin
    stall_cycles_q <= stall_cycles_d;
    flush_events_q <= flush_events_d;
  end

  // Only branches and jumps ever flush IF/ID, so that op identifies a flush
  // event; memory freezes are excluded from the stall count.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (reset) begin
      stall_cycles_d = 32'd0;
      flush_events_d = 32'd0;
    end else begin
      if (pc_hold && !mem_busy) begin
        stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (if_id_op == OP_FLUSH) begin
        flush_events_d = flush_events_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  // Counters are not built; the controller behaves identically without them.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. Two instances share the same inputs:
// u_dut uses LOAD_LAT=3, MD_LAT=4 and u_dut2 uses LOAD_LAT=2, MD_LAT=4, so
// both bubble lengths are exercised by the same stimulus. Outputs are packed
// as {if_id_op, id_ex_op, ex_mem_op, pc_hold} and sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] NORM = 7'b00_00_00_0;
  localparam logic [6:0] LS   = 7'b10_01_00_1;
  localparam logic [6:0] MDB  = 7'b10_10_01_1;
  localparam logic [6:0] FRZ  = 7'b10_10_10_1;
  localparam logic [6:0] BR   = 7'b01_01_00_0;
  localparam logic [6:0] JMP  = 7'b01_00_00_0;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_busy;
  logic       ex_mem_branch_taken;
  logic       id_ex_jump;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rt;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       md_start;

  logic [1:0] if_id_op, id_ex_op, ex_mem_op;
  logic       pc_hold;
  logic [1:0] if_id_op2, id_ex_op2, ex_mem_op2;
  logic       pc_hold2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  logic [31:0] stall_cycles2, flush_events2;
`endif

  int vectorCount = 0;
  int missCount   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .MD_LAT(4)) u_dut (
    .clk                 (clk),
    .reset               (reset),
    .mem_busy            (mem_busy),
    .ex_mem_branch_taken (ex_mem_branch_taken),
    .id_ex_jump          (id_ex_jump),
    .id_ex_mem_read      (id_ex_mem_read),
    .id_ex_rt            (id_ex_rt),
    .if_id_rs            (if_id_rs),
    .if_id_rt            (if_id_rt),
    .md_start            (md_start),
    .if_id_op            (if_id_op),
    .id_ex_op            (id_ex_op),
    .ex_mem_op           (ex_mem_op),
    .pc_hold             (pc_hold)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles        (stall_cycles),
    .flush_events        (flush_events)
`endif
  );

  pipe_hazard_ctrl #(.REG_W(5), .LOAD_LAT(2), .MD_LAT(4)) u_dut2 (
    .clk                 (clk),
    .reset               (reset),
    .mem_busy            (mem_busy),
    .ex_mem_branch_taken (ex_mem_branch_taken),
    .id_ex_jump          (id_ex_jump),
    .id_ex_mem_read      (id_ex_mem_read),
    .id_ex_rt            (id_ex_rt),
    .if_id_rs            (if_id_rs),
    .if_id_rt            (if_id_rt),
    .md_start            (md_start),
    .if_id_op            (if_id_op2),
    .id_ex_op            (id_ex_op2),
    .ex_mem_op           (ex_mem_op2),
    .pc_hold             (pc_hold2)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles        (stall_cycles2),
    .flush_events        (flush_events2)
`endif
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  // Drives every DUT input with blocking assignments.
  task automatic applyStimulus(input logic rst, input logic mb, input logic br,
                               input logic jmp, input logic mr,
                               input logic [4:0] ex_rt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic md);
    reset               = rst;
    mem_busy            = mb;
    ex_mem_branch_taken = br;
    id_ex_jump          = jmp;
    id_ex_mem_read      = mr;
    id_ex_rt            = ex_rt;
    if_id_rs            = rs;
    if_id_rt            = rt;
    md_start            = md;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Called 1 time unit after a rising edge: checks both instances mid-cycle,
  // then advances to 1 time unit after the next rising edge.
  task automatic cyc(input string tag, input logic [6:0] exp1, input logic [6:0] exp2);
    #3;
    checkOutput({tag, "/lat3"}, {25'd0, if_id_op, id_ex_op, ex_mem_op, pc_hold}, {25'd0, exp1});
    checkOutput({tag, "/lat2"}, {25'd0, if_id_op2, id_ex_op2, ex_mem_op2, pc_hold2}, {25'd0, exp2});
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] pipe_hazard_ctrl directed test start");

    // Reset dominates every other input.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 5'd8, 1'b1);
    #1;
    cyc("rst_out", NORM, NORM);
    cyc("rst_hold", NORM, NORM);
    applyIdle();
    cyc("idle", NORM, NORM);

    // Load-use on rs: 3 (resp. 2) bubble cycles.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0);
    cyc("lu_rs_c1", LS, LS);
    applyIdle();
    cyc("lu_rs_c2", LS, LS);
    cyc("lu_rs_c3", LS, NORM);
    cyc("lu_rs_end", NORM, NORM);

    // Load-use on rt.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd2, 5'd5, 1'b0);
    cyc("lu_rt_c1", LS, LS);
    applyIdle();
    cyc("lu_rt_c2", LS, LS);
    cyc("lu_rt_c3", LS, NORM);
    cyc("lu_rt_end", NORM, NORM);

    // Register 0 never stalls; matching registers without a load never stall.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("r0_nostall", NORM, NORM);
    applyIdle();
    cyc("r0_after", NORM, NORM);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 5'd8, 1'b0);
    cyc("noload", NORM, NORM);

    // Jump wins over a simultaneous load-use; no stall follows.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    cyc("jmp_over_lu", JMP, JMP);
    applyIdle();
    cyc("jmp_nostall", NORM, NORM);

    // Load-use wins over md_start; no busy period follows.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1);
    cyc("md_lu_c1", LS, LS);
    applyIdle();
    cyc("md_lu_c2", LS, LS);
    cyc("md_lu_c3", LS, NORM);
    cyc("md_lu_end", NORM, NORM);

    // Multiply/divide: normal on start, then MD_LAT=4 busy cycles.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    cyc("md_start", NORM, NORM);
    applyIdle();
    for (int i = 0; i < 4; i++) cyc("md_busy", MDB, MDB);
    cyc("md_end", NORM, NORM);

    // Branch at the 2nd busy cycle aborts the busy period.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    cyc("md2_start", NORM, NORM);
    applyIdle();
    cyc("md2_b1", MDB, MDB);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("md2_branch", BR, BR);
    applyIdle();
    cyc("md2_abort", NORM, NORM);
    cyc("md2_stay", NORM, NORM);

    // Branch aborts a load stall.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    cyc("ls_br_c1", LS, LS);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("ls_branch", BR, BR);
    applyIdle();
    cyc("ls_abort", NORM, NORM);

    // Memory freeze in the middle of a load stall; stall resumes afterwards.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    cyc("frz_c1", LS, LS);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("frz_1", FRZ, FRZ);
    cyc("frz_2", FRZ, FRZ);
    applyIdle();
    cyc("frz_res1", LS, LS);
    cyc("frz_res2", LS, NORM);
    cyc("frz_end", NORM, NORM);

    // mem_busy outranks a branch.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("mb_over_br", FRZ, FRZ);
    applyIdle();
    cyc("mb_br_after", NORM, NORM);

    // Reset in the middle of a busy period.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    cyc("md3_start", NORM, NORM);
    applyIdle();
    cyc("md3_b1", MDB, MDB);
    cyc("md3_b2", MDB, MDB);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("rst_mid_md", NORM, NORM);
    applyIdle();
    cyc("rst_idle1", NORM, NORM);
    cyc("rst_idle2", NORM, NORM);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("perf_rst_stall", stall_cycles, 32'd0);
    checkOutput("perf_rst_flush", flush_events, 32'd0);
    checkOutput("perf_rst_stall2", stall_cycles2, 32'd0);
    checkOutput("perf_rst_flush2", flush_events2, 32'd0);
`endif

    // One load stall plus one jump, counted from a clean reset.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    cyc("perf_lu_c1", LS, LS);
    applyIdle();
    cyc("perf_lu_c2", LS, LS);
    cyc("perf_lu_c3", LS, NORM);
    cyc("perf_lu_end", NORM, NORM);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc("perf_jmp", JMP, JMP);
    applyIdle();
    cyc("perf_after", NORM, NORM);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("perf_stall_lat3", stall_cycles, 32'd3);
    checkOutput("perf_flush_lat3", flush_events, 32'd1);
    checkOutput("perf_stall_lat2", stall_cycles2, 32'd2);
    checkOutput("perf_flush_lat2", flush_events2, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
